cmd_decision_unit: RTL

CMD_DECISION_UNIT -- requirements
Module: cmd_decision_unit

---
 rtl/cmd_decision_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cmd_decision_unit.sv
// Command decision FSM: collects N_TEMPLATES correlation scores, keeps the best one
// and emits a one-cycle verdict strobe (recognised / rejected / timed out).
module cmd_decision_unit #(
    parameter int unsigned          NB_SCORE    = 16,
    parameter int unsigned          N_TEMPLATES = 4,
    parameter logic [NB_SCORE-1:0]  THRESHOLD   = NB_SCORE'(20000),
    parameter int unsigned          TIMEOUT     = 1000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_init_done,
    input  logic                i_start,
    input  logic                i_score_valid,
    input  logic [NB_SCORE-1:0] i_score,
    output logic                o_idle,
    output logic                o_cmd_valid,
    output logic                o_cmd_recon,
    output logic [2:0]          o_cmd_id,
    output logic [NB_SCORE-1:0] o_best_score,
    output logic [1:0]          o_state
);

    localparam int unsigned CNT_W = $clog2(N_TEMPLATES + 1);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TEMPLATES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_COLLECT   = 2'd2,
        ST_REPORT    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NB_SCORE-1:0] best_q, best_d;
    logic [2:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                recon_q, recon_d;
    logic [2:0]          id_q, id_d;
    logic [NB_SCORE-1:0] out_score_q, out_score_d;

    // Score handshake: i_score_valid has no ready; a score is consumed in exactly the
    // cycles the FSM is in COLLECT and dropped silently in every other state.
    logic                take;
    logic                beats;
    logic                set_done;
    logic                tmo_hit;
    logic [NB_SCORE-1:0] cand_score;
    logic [2:0]          cand_idx;

    assign take       = (state_q == ST_COLLECT) && i_score_valid;
    // The first score of a set always loads so that an all-zero set still reports index 0.
    assign beats      = (cnt_q == '0) || (i_score > best_q);
    assign cand_score = (take && beats) ? i_score : best_q;
    assign cand_idx   = (take && beats) ? 3'(cnt_q) : idx_q;
    assign set_done   = take && (cnt_q == LAST_IDX);
    assign tmo_hit    = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        best_d      = best_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        recon_d     = recon_q;
        id_d        = id_q;
        out_score_d = out_score_q;

        case (state_q)
            ST_WAIT_INIT: begin
                if (i_init_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!i_init_done) begin
                    state_d = ST_WAIT_INIT;
                end else if (i_start) begin
                    state_d = ST_COLLECT;
                    best_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (!i_init_done) begin
                    state_d = ST_WAIT_INIT;
                end else begin
                    if (take) begin
                        cnt_d  = cnt_q + 1'b1;
                        best_d = cand_score;
                        idx_d  = cand_idx;
                    end
                    // A full set on the last allowed cycle still counts as a real decision.
                    if (set_done) begin
                        state_d     = ST_REPORT;
                        recon_d     = (cand_score >= THRESHOLD);
                        id_d        = cand_idx;
                        out_score_d = cand_score;
                    end else if (tmo_hit) begin
                        state_d     = ST_REPORT;
                        recon_d     = 1'b0;
                        id_d        = '0;
                        out_score_d = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                state_d = i_init_done ? ST_IDLE : ST_WAIT_INIT;
            end
            default: begin
                state_d = ST_WAIT_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_WAIT_INIT;
            best_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            recon_q     <= 1'b0;
            id_q        <= '0;
            out_score_q <= '0;
        end else begin
            state_q     <= state_d;
            best_q      <= best_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            recon_q     <= recon_d;
            id_q        <= id_d;
            out_score_q <= out_score_d;
        end
    end

    assign o_idle       = (state_q == ST_IDLE);
    assign o_cmd_valid  = (state_q == ST_REPORT);
    assign o_cmd_recon  = recon_q;
    assign o_cmd_id     = id_q;
    assign o_best_score = out_score_q;
    assign o_state      = state_q;

endmodule
